creek_run_ctrl: RTL
===================

// Module: creek_run_ctrl
// PURPOSE
//  Avalon-MM slave between the HPS lightweight bridge and the Creek core.
//  - Loads the instruction memory, and runs/halts the core via pause_n.
//  - Counts run cycles and reports completion.
//  - Replaces the fixed ctrl/instr_mem glue with a parametrised run-control block.
// PARAMETERS
//  ADDR_WIDTH   10  instruction memory address width (words)
//  INSTR_WIDTH  16  instruction word width
//  PC_WIDTH     10  core PC width
//  STATE_WIDTH  5   core state width
//  CYCLE_WIDTH  32  run-cycle counter width (<=32)
//  TRACE_DEPTH  16  trace FIFO entries, power of 2 (CREEK_TRACE_EN only)
//  Constraint: INSTR_WIDTH+PC_WIDTH+STATE_WIDTH <= 32
// PORTS
//  clk              in   1            single clock; all logic on its rising edge
//  reset_n          in   1            asynchronous, active-low reset
//  avs_address      in   ADDR_WIDTH+1 [MSB]=1: imem window; [MSB]=0: registers ([1:0])
//  avs_write        in   1            write strobe, 1-cycle, no waitrequest
//  avs_writedata    in   32           write data
//  avs_read         in   1            read strobe
//  avs_readdata     out  32           read data, valid exactly 1 cycle after avs_read
//  im_wraddr        out  ADDR_WIDTH   imem write address
//  im_wrdata        out  INSTR_WIDTH  imem write data
//  im_wren          out  1            imem write enable, 1-cycle pulse
//  pause_n          out  1            core run enable
//  local_init_done  in   1            memory init complete
//  waiting          in   1            core idle/finished
//  cur_pc           in   PC_WIDTH     core PC (trace)
//  cur_instr        in   INSTR_WIDTH  core instruction (trace)
//  cur_state        in   STATE_WIDTH  core state (trace)
// BEHAVIOUR
//  Reset: avs_readdata=0, im_wren=0, im_wraddr=0, im_wrdata=0, pause_n=0.
//         FSM=IDLE, cycles=0, err=0, waiting_q=1.
//  Registers (MSB=0, addr[1:0]):
//   0 CTRL/STATUS  W: bit0 start, bit1 halt, bit2 clr_err
//                  R: {27'b0, ovf, err, busy, fsm[1:0]}
//   1 CYCLES       R: run-cycle count, zero-extended; writes ignored
//   2 LASTPC       R: {state, pc} captured on entering DONE
//   3 TRACE        R: pop one FIFO entry (see CONFIGURATION)
//  Imem window:
//   - write in IDLE/DONE -> next cycle im_wren=1 with registered addr/data
//     (writedata[INSTR_WIDTH-1:0]); 1-cycle latency
//   - write in WAIT_INIT/RUN -> dropped, no im_wren, err<=1
//   - reads of the window return 0
//  FSM (encoding IDLE=0, WAIT_INIT=1, RUN=2, DONE=3); busy = WAIT_INIT|RUN:
//   IDLE/DONE + start                 -> WAIT_INIT; cycles<=0
//   WAIT_INIT + local_init_done       -> RUN
//   RUN + waiting rising edge         -> DONE; LASTPC captured
//     (edge = waiting & ~waiting_q; waiting_q registered every cycle)
//   WAIT_INIT/RUN + halt              -> IDLE
//   start+halt in the same write      -> halt wins
//   start while busy                  -> ignored
//  pause_n = 1 only in RUN, registered from next state; zero-latency to the FSM state.
//  cycles: +1 per cycle in RUN; saturates at all-ones (no wrap); held in DONE/IDLE.
//  clr_err: clears err and ovf. A drop in the same cycle as clr_err leaves err=1 (set wins).
//  Async reset mid-run: pause_n drops immediately; imem contents are not touched.
// CONFIGURATION
//  CREEK_TRACE_EN defined:
//   - FIFO of TRACE_DEPTH entries {cur_state, cur_pc, cur_instr}, LSB-aligned
//   - push each RUN cycle where cur_pc != previous cycle's cur_pc
//   - full: new entry dropped, ovf<=1
//   - reg 3 read returns the head and pops; empty returns 32'hFFFF_FFFF, no pop
//   - push+pop same cycle when full: both succeed
//   - FIFO flushed on start
//  CREEK_TRACE_EN undefined:
//   - no FIFO logic; reg 3 reads 0; ovf reads 0
//   - cur_pc/cur_instr/cur_state used only for LASTPC
// TESTING
//  1 Reset, then write imem addr 5 data 0xBEEF in IDLE
//    -> im_wren 1 cycle later, im_wraddr=5, im_wrdata=0xBEEF, err=0.
//  2 Write start with local_init_done=0 for 10 cycles, then 1
//    -> fsm=1, pause_n=0 throughout; RUN and pause_n=1 the cycle after init.
//  3 RUN 100 cycles, then waiting 0->1
//    -> DONE, pause_n=0, CYCLES=100, LASTPC matches core pc/state.
//  4 Imem write during RUN -> no im_wren, STATUS err=1.
//    clr_err -> err=0. Start+halt in one write from IDLE -> stays IDLE.
//  5 CYCLE_WIDTH=4, run 20 cycles -> CYCLES=15 (saturated).
//    Halt in RUN -> IDLE, pause_n=0 next cycle.
//  6 CREEK_TRACE_EN, TRACE_DEPTH=4, pc changes 6 times
//    -> 4 pops return first 4 entries in order, 5th pop=0xFFFFFFFF, ovf=1.

Source files
------------

// File: rtl/creek_run_ctrl.sv
// creek_run_ctrl: Avalon-MM run-control slave that loads Creek imem, runs/halts the core, counts run cycles, reports completion
// Optional trace FIFO is built only when the macro CREEK_TRACE_EN is defined.
// Ports: clk, reset_n (async active-low); avs_* Avalon-MM slave (addr MSB selects imem window vs registers);
//        im_wraddr/im_wrdata/im_wren imem write port; pause_n core run enable;
//        local_init_done, waiting core status; cur_pc/cur_instr/cur_state core observation for LASTPC/trace.
module creek_run_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int INSTR_WIDTH = 16,
  parameter int PC_WIDTH    = 10,
  parameter int STATE_WIDTH = 5,
  parameter int CYCLE_WIDTH = 32,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_WIDTH:0]    avs_address,
  input  logic                   avs_write,
  input  logic [31:0]            avs_writedata,
  input  logic                   avs_read,
  output logic [31:0]            avs_readdata,
  output logic [ADDR_WIDTH-1:0]  im_wraddr,
  output logic [INSTR_WIDTH-1:0] im_wrdata,
  output logic                   im_wren,
  output logic                   pause_n,
  input  logic                   local_init_done,
  input  logic                   waiting,
  input  logic [PC_WIDTH-1:0]    cur_pc,
  input  logic [INSTR_WIDTH-1:0] cur_instr,
  input  logic [STATE_WIDTH-1:0] cur_state
);
  typedef enum logic [1:0] {IDLE, WAIT_INIT, RUN, DONE} state_t;
  state_t state, state_nx;
  logic waiting_q, err, ovf, busy, reg_sel, ctrl_wr, start, halt, clr_err, im_wr, im_ok, go, done_edge;
  logic [CYCLE_WIDTH-1:0] cycles;
  logic [STATE_WIDTH+PC_WIDTH-1:0] lastpc;
  logic [31:0] rd_mux, trace_rd;
  logic unused_bits;
  assign unused_bits = ^{avs_writedata, cur_instr, 1'(TRACE_DEPTH)};
  assign reg_sel   = ~avs_address[ADDR_WIDTH];
  assign ctrl_wr   = avs_write & reg_sel & (avs_address[1:0] == 2'd0);
  assign start     = ctrl_wr & avs_writedata[0];
  assign halt      = ctrl_wr & avs_writedata[1];
  assign clr_err   = ctrl_wr & avs_writedata[2];
  assign busy      = (state == WAIT_INIT) | (state == RUN);
  assign im_wr     = avs_write & ~reg_sel;
  assign im_ok     = im_wr & ~busy;
  // halt suppresses start in the same write; start while busy is ignored
  assign go        = start & ~halt & ~busy;
  assign done_edge = (state == RUN) & waiting & ~waiting_q;
  always_comb begin
    state_nx = state;
    state_nx = (halt & busy) ? IDLE :
               go ? WAIT_INIT :
               (state == WAIT_INIT && local_init_done) ? RUN :
               done_edge ? DONE : state;
  end
  assign rd_mux = ~reg_sel ? 32'd0 :
                  (avs_address[1:0] == 2'd0) ? {27'd0, ovf, err, busy, state} :
                  (avs_address[1:0] == 2'd1) ? 32'(cycles) :
                  (avs_address[1:0] == 2'd2) ? 32'(lastpc) : trace_rd;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pause_n      <= 1'b0;
      waiting_q    <= 1'b1;
      cycles       <= '0;
      err          <= 1'b0;
      lastpc       <= '0;
      avs_readdata <= '0;
      im_wren      <= 1'b0;
      im_wraddr    <= '0;
      im_wrdata    <= '0;
    end else begin
      state        <= state_nx;
      pause_n      <= state_nx == RUN;
      waiting_q    <= waiting;
      cycles       <= go ? '0 : (state == RUN && ~&cycles) ? cycles + CYCLE_WIDTH'(1) : cycles;
      err          <= (im_wr & busy) | (err & ~clr_err);
      avs_readdata <= avs_read ? rd_mux : 32'd0;
      im_wren      <= im_ok;
      if (state == RUN && state_nx == DONE) lastpc <= {cur_state, cur_pc};
      if (im_ok) begin
        im_wraddr <= avs_address[ADDR_WIDTH-1:0];
        im_wrdata <= avs_writedata[INSTR_WIDTH-1:0];
      end
    end
  end
`ifdef CREEK_TRACE_EN
  localparam int PW = $clog2(TRACE_DEPTH);
  logic [31:0] fifo [TRACE_DEPTH];
  logic [PW:0] wp, rp;
  logic [PC_WIDTH-1:0] pc_q;
  logic push, pop, full, empty, drop, wr_en;
  assign empty    = wp == rp;
  // pointers carry one extra wrap bit: full when indices match but wrap bits differ
  assign full     = (wp ^ rp) == {1'b1, {PW{1'b0}}};
  assign pop      = avs_read & reg_sel & (avs_address[1:0] == 2'd3) & ~empty;
  assign push     = (state == RUN) & (cur_pc != pc_q);
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign drop     = push & full & ~pop;
  assign wr_en    = push & ~drop;
  assign trace_rd = empty ? 32'hFFFF_FFFF : fifo[rp[PW-1:0]];
  always_ff @(posedge clk) begin
    if (wr_en) fifo[wp[PW-1:0]] <= 32'({cur_state, cur_pc, cur_instr});
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp   <= '0;
      rp   <= '0;
      pc_q <= '0;
      ovf  <= 1'b0;
    end else begin
      pc_q <= cur_pc;
      wp   <= go ? '0 : wp + {{PW{1'b0}}, wr_en};
      rp   <= go ? '0 : rp + {{PW{1'b0}}, pop};
      ovf  <= drop | (ovf & ~clr_err);
    end
  end
`else
  assign ovf      = 1'b0;
  assign trace_rd = 32'd0;
`endif
endmodule
